redmule_mem_sched: RTL and testbench

REDMULE_MEM_SCHED -- requirements
Module: redmule_mem_sched

---
 rtl/redmule_mem_sched.sv | 153 +++++++++++++++
 tb/tb_redmule_mem_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_mem_sched.sv
// redmule_mem_sched: round-robin burst scheduler that hands the streamer port to one requester per burst.
// Define REDMULE_SCHED_WPRIO_EN to give the W load priority with bounded starvation of the others.
module redmule_mem_sched #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned MAX_SKIP = 3,
  localparam int unsigned SEL_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     enable_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*LEN_W-1:0] len_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic                     port_valid_o,
  input  logic                     port_ready_i,
  output logic [SEL_W-1:0]         port_sel_o,
  output logic [LEN_W-1:0]         beat_idx_o,
  output logic                     busy_o
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  // The skip counter is sized from MAX_SKIP + 1, so keep that sum inside 32 bits.
  if (MAX_SKIP >= 32'h8000_0000) begin : g_max_skip_range
    $error("MAX_SKIP out of range");
  end

  state_t             r_state;
  logic [SEL_W-1:0]   r_last;
  logic [SEL_W-1:0]   r_sel;
  logic [NUM_REQ-1:0] r_gnt;
  logic [LEN_W-1:0]   r_beat;
  logic [LEN_W-1:0]   r_len_m1;
  logic               r_valid;
  logic               r_busy;

  logic [SEL_W-1:0]   w_rr_idx;
  logic               w_rr_found;
  logic [SEL_W-1:0]   w_win;
  logic [LEN_W-1:0]   w_win_len;
  logic [LEN_W-1:0]   w_win_len_m1;
  logic               w_accept;
  logic               w_last;

  // Round-robin candidate: first requester after the previous winner.
  always_comb begin : rr_search
    logic [SEL_W-1:0] v_idx;
    v_idx      = '0;
    w_rr_idx   = r_last;
    w_rr_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      v_idx = SEL_W'((32'(r_last) + k) % NUM_REQ);
      if (!w_rr_found && req_i[v_idx]) begin
        w_rr_idx   = v_idx;
        w_rr_found = 1'b1;
      end
    end
  end

`ifdef REDMULE_SCHED_WPRIO_EN
  localparam int unsigned W_IDX  = 1;
  localparam int unsigned SKIP_W = (MAX_SKIP > 0) ? $clog2(MAX_SKIP + 1) : 1;

  logic [SKIP_W-1:0] r_skip;
  logic              w_w_override;

  // W jumps the queue until it has bypassed MAX_SKIP other candidates in a row.
  always_comb begin : w_prio
    w_w_override = req_i[W_IDX] && (w_rr_idx != SEL_W'(W_IDX)) &&
                   (r_skip != SKIP_W'(MAX_SKIP));
    w_win        = w_w_override ? SEL_W'(W_IDX) : w_rr_idx;
  end
`else
  assign w_win = w_rr_idx;
`endif

  always_comb begin : len_mux
    w_win_len = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_win == SEL_W'(i)) begin
        w_win_len = len_i[i*LEN_W +: LEN_W];
      end
    end
    w_win_len_m1 = (w_win_len == '0) ? '0 : w_win_len - LEN_W'(1);
  end

  assign w_accept = r_valid && port_ready_i;
  assign w_last   = (r_beat == r_len_m1);

  // Burst completion is reported in the cycle the last beat is accepted.
  assign done_o       = (w_accept && w_last && !clear_i) ? r_gnt : '0;
  assign gnt_o        = r_gnt;
  assign port_valid_o = r_valid;
  assign port_sel_o   = r_sel;
  assign beat_idx_o   = r_beat;
  assign busy_o       = r_busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin : fsm
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_last   <= SEL_W'(NUM_REQ - 1);
      r_sel    <= '0;
      r_gnt    <= '0;
      r_beat   <= '0;
      r_len_m1 <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
`ifdef REDMULE_SCHED_WPRIO_EN
      r_skip   <= '0;
`endif
    end else if (clear_i) begin
      r_state  <= S_IDLE;
      r_last   <= SEL_W'(NUM_REQ - 1);
      r_sel    <= '0;
      r_gnt    <= '0;
      r_beat   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
`ifdef REDMULE_SCHED_WPRIO_EN
      r_skip   <= '0;
`endif
    end else if (r_state == S_IDLE) begin
      if (enable_i && w_rr_found) begin
        r_state  <= S_BURST;
        r_last   <= w_win;
        r_sel    <= w_win;
        r_gnt    <= NUM_REQ'(1) << w_win;
        r_beat   <= '0;
        r_len_m1 <= w_win_len_m1;
        r_valid  <= 1'b1;
        r_busy   <= 1'b1;
`ifdef REDMULE_SCHED_WPRIO_EN
        r_skip   <= w_w_override ? r_skip + SKIP_W'(1) : '0;
`endif
      end
    end else if (w_accept) begin
      if (w_last) begin
        r_state <= S_IDLE;
        r_sel   <= '0;
        r_gnt   <= '0;
        r_beat  <= '0;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        r_beat  <= r_beat + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_redmule_mem_sched.sv
// tb_redmule_mem_sched: directed vector table plus hand-written sequences for stalls, clear and W priority.
module tb_redmule_mem_sched;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned LEN_W   = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        enable_i;
  logic [3:0]  req_i;
  logic [31:0] len_i;
  logic [3:0]  gnt_o;
  logic [3:0]  done_o;
  logic        port_valid_o;
  logic        port_ready_i;
  logic [1:0]  port_sel_o;
  logic [7:0]  beat_idx_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  redmule_mem_sched #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .MAX_SKIP(3)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .enable_i     (enable_i),
    .req_i        (req_i),
    .len_i        (len_i),
    .gnt_o        (gnt_o),
    .done_o       (done_o),
    .port_valid_o (port_valid_o),
    .port_ready_i (port_ready_i),
    .port_sel_o   (port_sel_o),
    .beat_idx_o   (beat_idx_o),
    .busy_o       (busy_o)
  );

  typedef struct {
    logic       clr;
    logic       en;
    logic [3:0] req;
    logic [7:0] len;
    logic       rdy;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       vld;
    logic [1:0] sel;
    logic [7:0] beat;
    logic       busy;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic clr, input logic en, input logic [3:0] req,
                              input logic [7:0] len, input logic rdy, input logic [3:0] gnt,
                              input logic [3:0] done, input logic vld, input logic [1:0] sel,
                              input logic [7:0] beat, input logic busy);
    vec_t v;
    v.clr = clr; v.en = en; v.req = req; v.len = len; v.rdy = rdy;
    v.gnt = gnt; v.done = done; v.vld = vld; v.sel = sel; v.beat = beat; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [3:0] e_gnt, input logic [3:0] e_done,
                            input logic e_vld, input logic [1:0] e_sel, input logic [7:0] e_beat,
                            input logic e_busy);
    logic [19:0] act;
    logic [19:0] exp;
    act = {gnt_o, done_o, port_valid_o, port_sel_o, beat_idx_o, busy_o};
    exp = {e_gnt, e_done, e_vld, e_sel, e_beat, e_busy};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got gnt=%b done=%b vld=%b sel=%0d beat=%0d busy=%b; expected gnt=%b done=%b vld=%b sel=%0d beat=%0d busy=%b",
               name, gnt_o, done_o, port_valid_o, port_sel_o, beat_idx_o, busy_o,
               e_gnt, e_done, e_vld, e_sel, e_beat, e_busy);
    end
  endtask

  task automatic check_idle(input string name);
    check_outs(name, 4'b0, 4'b0, 1'b0, 2'd0, 8'd0, 1'b0);
  endtask

  // Drive one cycle's inputs after the falling edge, then let them settle before sampling.
  task automatic step(input logic clr, input logic en, input logic [3:0] req,
                      input logic [7:0] len, input logic rdy);
    @(negedge clk_i);
    clear_i      = clr;
    enable_i     = en;
    req_i        = req;
    len_i        = {4{len}};
    port_ready_i = rdy;
    #1;
  endtask

  task automatic do_reset();
    rst_ni       = 1'b0;
    clear_i      = 1'b0;
    enable_i     = 1'b0;
    req_i        = 4'b0;
    len_i        = '0;
    port_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_owner[5];
    logic       got;

    //               clr en  req     len  rdy  gnt     done    vld sel beat busy
    vecs[0]  = mk(0, 1, 4'hF, 2, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 4'hF, 2, 1, 4'b0001, 4'b0000, 1, 0, 0, 1);
    vecs[2]  = mk(0, 1, 4'hF, 2, 1, 4'b0001, 4'b0001, 1, 0, 1, 1);
    vecs[3]  = mk(0, 1, 4'hF, 2, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vecs[4]  = mk(0, 1, 4'hF, 2, 1, 4'b0010, 4'b0000, 1, 1, 0, 1);
    vecs[5]  = mk(0, 1, 4'hF, 2, 1, 4'b0010, 4'b0010, 1, 1, 1, 1);
    vecs[6]  = mk(0, 1, 4'hF, 2, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 4'hF, 2, 1, 4'b0100, 4'b0000, 1, 2, 0, 1);
    vecs[8]  = mk(0, 1, 4'hF, 2, 1, 4'b0100, 4'b0100, 1, 2, 1, 1);
    vecs[9]  = mk(0, 1, 4'hF, 2, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vecs[10] = mk(0, 1, 4'hF, 2, 1, 4'b1000, 4'b0000, 1, 3, 0, 1);
    vecs[11] = mk(0, 1, 4'hF, 2, 1, 4'b1000, 4'b1000, 1, 3, 1, 1);
    vecs[12] = mk(0, 1, 4'h4, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vecs[13] = mk(0, 1, 4'h0, 0, 1, 4'b0100, 4'b0100, 1, 2, 0, 1);
    vecs[14] = mk(0, 1, 4'h0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 4'h1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 4'h1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vecs[17] = mk(0, 1, 4'h1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vecs[18] = mk(0, 1, 4'h0, 0, 1, 4'b0001, 4'b0001, 1, 0, 0, 1);
    vecs[19] = mk(0, 1, 4'h0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);

    do_reset();
    check_idle("reset_state");
    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].clr, vecs[i].en, vecs[i].req, vecs[i].len, vecs[i].rdy);
      check_outs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].done, vecs[i].vld,
                 vecs[i].sel, vecs[i].beat, vecs[i].busy);
    end

    // Stall after beat 1 of a 4-beat burst; mid-burst req/len changes must be ignored.
    do_reset();
    step(0, 1, 4'b0001, 8'd4, 1);
    check_idle("stall_pre");
    step(0, 1, 4'b0000, 8'd1, 1);
    check_outs("stall_beat0", 4'b0001, 4'b0000, 1, 0, 0, 1);
    for (int c = 0; c < 5; c++) begin
      step(0, 1, 4'b0000, 8'd1, 0);
      check_outs($sformatf("stall_hold%0d", c), 4'b0001, 4'b0000, 1, 0, 1, 1);
    end
    step(0, 1, 4'b0000, 8'd1, 1);
    check_outs("stall_beat1", 4'b0001, 4'b0000, 1, 0, 1, 1);
    step(0, 1, 4'b0000, 8'd1, 1);
    check_outs("stall_beat2", 4'b0001, 4'b0000, 1, 0, 2, 1);
    step(0, 1, 4'b0000, 8'd1, 1);
    check_outs("stall_beat3", 4'b0001, 4'b0001, 1, 0, 3, 1);
    step(0, 1, 4'b0000, 8'd1, 1);
    check_idle("stall_after");

    // Clear mid-burst returns to IDLE and restarts round-robin from requester 0.
    do_reset();
    step(0, 1, 4'b0010, 8'd8, 1);
    step(0, 1, 4'b0000, 8'd8, 1);
    check_outs("clr_beat0", 4'b0010, 4'b0000, 1, 1, 0, 1);
    step(0, 1, 4'b0000, 8'd8, 1);
    check_outs("clr_beat1", 4'b0010, 4'b0000, 1, 1, 1, 1);
    step(1, 1, 4'b0000, 8'd8, 1);
    check_outs("clr_beat2", 4'b0010, 4'b0000, 1, 1, 2, 1);
    step(0, 1, 4'b1111, 8'd1, 1);
    check_idle("clr_idle");
    step(0, 1, 4'b0000, 8'd1, 1);
    check_outs("clr_regrant", 4'b0001, 4'b0001, 1, 0, 0, 1);
    step(0, 1, 4'b0100, 8'd1, 1);
    check_idle("clr_gap");
    step(1, 1, 4'b0000, 8'd1, 1);
    check_outs("clr_last_nodone", 4'b0100, 4'b0000, 1, 2, 0, 1);
    step(0, 1, 4'b0000, 8'd1, 1);
    check_idle("clr_last_idle");

    // Reset takes effect asynchronously in the middle of a burst.
    do_reset();
    step(0, 1, 4'b1000, 8'd4, 1);
    step(0, 1, 4'b0000, 8'd4, 1);
    check_outs("arst_busy", 4'b1000, 4'b0000, 1, 3, 0, 1);
    #2 rst_ni = 1'b0;
    #1;
    check_idle("arst_async");

    // Requester pattern 1011 with single-beat bursts: grant order depends on W priority.
`ifdef REDMULE_SCHED_WPRIO_EN
    exp_owner[0] = 2'd1; exp_owner[1] = 2'd1; exp_owner[2] = 2'd1;
    exp_owner[3] = 2'd3; exp_owner[4] = 2'd1;
`else
    exp_owner[0] = 2'd0; exp_owner[1] = 2'd1; exp_owner[2] = 2'd3;
    exp_owner[3] = 2'd0; exp_owner[4] = 2'd1;
`endif
    do_reset();
    for (int b = 0; b < 5; b++) begin
      got = 1'b0;
      for (int c = 0; c < 4; c++) begin
        step(0, 1, 4'b1011, 8'd1, 1);
        if (busy_o) begin
          got = 1'b1;
          break;
        end
      end
      chk($sformatf("order%0d_busy", b), 32'(got), 32'd1);
      chk($sformatf("order%0d_owner", b), 32'(port_sel_o), 32'(exp_owner[b]));
      chk($sformatf("order%0d_done", b), 32'(done_o), 32'(4'b0001 << exp_owner[b]));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
